univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal register, the next generation of the team's 4-bit parallel-in/parallel-out register. It adds synchronous reset, clock enable, and four modes: hold, shift right, shift left and parallel load. A shift counter pulses word_done once a full word has been shifted out since the last load or reset. It is used as a PIPO, SIPO, PISO or SISO stage in serial-link and datapath front ends.

Parameters:
WIDTH, 4, register width in bits (>=1)
RESET_VAL, 0, value of d_out after reset (WIDTH bits)
CNT_W, max(1, clog2(WIDTH)), width of shift_cnt (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
en  input  1  clock enable; 0 = hold everything
mode  input  2  00 hold, 01 shift right, 10 shift left, 11 parallel load
d_in  input  WIDTH  parallel load data
ser_in_r  input  1  serial bit entering the MSB on shift right
ser_in_l  input  1  serial bit entering the LSB on shift left
d_out  output  WIDTH  register contents
ser_out_r  output  1  d_out[0] (bit leaving on shift right); combinational tap of the register
ser_out_l  output  1  d_out[WIDTH-1] (bit leaving on shift left); combinational tap of the register
shift_cnt  output  CNT_W  shifts completed in the current word
word_done  output  1  one-cycle pulse after the WIDTH-th shift of a word

Behaviour:
- All state is registered on posedge clk. Latency is 1 cycle from inputs to d_out, shift_cnt and word_done.
- Priority order: rst > en=0 > mode.
- rst=1: d_out<=RESET_VAL, shift_cnt<=0, word_done<=0, regardless of en, mode or data.
- en=0: d_out and shift_cnt hold; word_done<=0.
- mode=00 (hold): d_out and shift_cnt hold; word_done<=0.
- mode=11 (load): d_out<=d_in, shift_cnt<=0, word_done<=0. A load mid-word abandons the partial count without asserting done.
- mode=01 (shift right): d_out<={ser_in_r, d_out[WIDTH-1:1]}.
- mode=10 (shift left): d_out<={d_out[WIDTH-2:0], ser_in_l}.
- Shift counting (either direction; mixed directions count together):
  - shift_cnt==WIDTH-1: shift_cnt<=0, word_done<=1.
  - otherwise: shift_cnt<=shift_cnt+1, word_done<=0.
- word_done is high for exactly one cycle per completed word. Back-to-back shifts wrap the count continuously and pulse once every WIDTH shifts.
- WIDTH=1: shift_cnt stays 0 and every shift pulses word_done. The shifts become d_out<=ser_in_r and d_out<=ser_in_l respectively.
- Reset mid-word discards both data and count; the next shift counts as shift 1.
- No X propagation: every output is defined from the first post-reset cycle.

Decomposition:
- Shared package usr_pkg:
  - mode constants MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11
  - 2-bit mode typedef
- Sub-module usr_bit_cell: one bit, i.e. a 4:1 mux (hold, right neighbour, left neighbour, d_in) feeding a D flip-flop with synchronous reset and enable. Instantiate WIDTH cells in a generate loop, with edge cells fed by ser_in_r/ser_in_l.
- The counter and word_done logic live in the top module.

Test Plan:
1. Reset priority (WIDTH=4, RESET_VAL=0): rst=1, en=1, mode=11, d_in=4'hF for 1 edge -> d_out=4'h0, shift_cnt=0, word_done=0.
2. Parallel-in/serial-out right: load 4'b1011, then 4 edges with mode=01, ser_in_r=0.
   - ser_out_r before each shift edge: 1,1,0,1.
   - d_out: 0101, 0010, 0001, 0000.
   - shift_cnt: 1,2,3,0.
   - word_done=1 only in the cycle after the 4th shift.
3. Serial-in left: from 0000, 4 edges with mode=10, ser_in_l=1 -> d_out 0001, 0011, 0111, 1111; word_done pulses after the 4th; ser_out_l=1 after the 4th edge.
4. Enable gating: d_out=4'hA, en=0, mode=11, d_in=4'h5 for 3 edges -> d_out stays 4'hA, shift_cnt unchanged, word_done=0.
5. Load mid-word: 2 shifts (shift_cnt=2), load 4'h6 -> shift_cnt=0 and no word_done; 4 further shifts are required before word_done pulses.
6. Reset mid-word plus mixed directions: 3 shifts, then rst=1 with mode=01 -> d_out=RESET_VAL, shift_cnt=0. Then shift right, shift left, shift right, shift left -> word_done pulses after the 4th. Repeat with WIDTH=1: every shift pulses word_done.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: shared mode encoding for the universal shift register.
//   MODE_HOLD  keep contents
//   MODE_SHR   shift toward bit 0, serial bit enters the MSB
//   MODE_SHL   shift toward the MSB, serial bit enters bit 0
//   MODE_LOAD  parallel load from d_in
package usr_pkg;

    typedef logic [1:0] usr_mode_t;

    localparam usr_mode_t MODE_HOLD = 2'b00;
    localparam usr_mode_t MODE_SHR  = 2'b01;
    localparam usr_mode_t MODE_SHL  = 2'b10;
    localparam usr_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/usr_bit_cell.sv
// usr_bit_cell: one register bit, a 4:1 mode mux in front of a flop with sync reset and enable.
//   clk_i       rising-edge clock
//   rst_i       synchronous reset, loads RST_VAL
//   en_i        clock enable
//   mode_i      hold / shift right / shift left / load
//   load_i      parallel load bit
//   shr_src_i   bit arriving on a right shift (upper neighbour or ser_in_r)
//   shl_src_i   bit arriving on a left shift (lower neighbour or ser_in_l)
//   q_o         stored bit
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      en_i,
    input  usr_mode_t mode_i,
    input  logic      load_i,
    input  logic      shr_src_i,
    input  logic      shl_src_i,
    output logic      q_o
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = (mode_i == MODE_LOAD) ? load_i    :
              (mode_i == MODE_SHL)  ? shl_src_i :
              (mode_i == MODE_SHR)  ? shr_src_i : q_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)     q_q <= RST_VAL;
        else if (en_i) q_q <= q_d;
    end

    assign q_o = q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal register (hold / shift right / shift left / load)
// with a shift counter that pulses word_done after every WIDTH shifts.
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   en         clock enable; 0 holds data and count
//   mode       00 hold, 01 shift right, 10 shift left, 11 parallel load
//   d_in       parallel load data
//   ser_in_r   serial bit entering the MSB on shift right
//   ser_in_l   serial bit entering the LSB on shift left
//   d_out      register contents
//   ser_out_r  d_out[0]
//   ser_out_l  d_out[WIDTH-1]
//   shift_cnt  shifts completed in the current word
//   word_done  one-cycle pulse after the WIDTH-th shift of a word
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int                WIDTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    localparam int               CNT_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  usr_mode_t        mode,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] d_out,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             word_done
);

    logic [WIDTH-1:0] d_q;
    // Padded views so every cell, edge cells included, picks its shift
    // source with the same index expression (also valid for WIDTH=1).
    logic [WIDTH:0]   shr_v;
    logic [WIDTH:0]   shl_v;

    assign shr_v = {ser_in_r, d_q};
    assign shl_v = {d_q, ser_in_l};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        usr_bit_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en),
            .mode_i    (mode),
            .load_i    (d_in[i]),
            .shr_src_i (shr_v[i+1]),
            .shl_src_i (shl_v[i]),
            .q_o       (d_q[i])
        );
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             done_q;
    logic             done_d;
    logic             shifting;
    logic             last;

    assign shifting = en && (mode == MODE_SHR || mode == MODE_SHL);
    // For WIDTH=1 the count is pinned at 0, so every shift is the last of its word.
    assign last     = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        cnt_d  = !en                ? cnt_q :
                 mode == MODE_LOAD  ? '0    :
                 shifting           ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
        done_d = shifting && last;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign d_out     = d_q;
    assign ser_out_r = d_q[0];
    assign ser_out_l = d_q[WIDTH-1];
    assign shift_cnt = cnt_q;
    assign word_done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: scoreboard bench for univ_shift_reg at WIDTH=4 and WIDTH=1.
module tb_univ_shift_reg;
    import usr_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    usr_mode_t  mode = MODE_HOLD;
    logic [3:0] d_in = '0;
    logic       ser_in_r = 1'b0;
    logic       ser_in_l = 1'b0;

    logic [3:0] d4;
    logic       r4, l4, w4;
    logic [1:0] c4;
    logic [0:0] d1;
    logic       r1, l1, w1;
    logic [0:0] c1;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) u_w4 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .d_out(d4),
        .ser_out_r(r4), .ser_out_l(l4), .shift_cnt(c4), .word_done(w4)
    );

    univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d_in(d_in[0:0]),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .d_out(d1),
        .ser_out_r(r1), .ser_out_l(l1), .shift_cnt(c1), .word_done(w1)
    );

    typedef struct {
        int d4, c4, w4, r4, l4;
        int d1, c1, w1, r1, l1;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total = 0;
    // Reference state: register value as an integer plus shifts since last load/reset.
    int   v4 = 0, t4 = 0, v1 = 0, t1 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    task automatic model(input int w, input int rv, inout int val, inout int tot, output int done);
        int mask = (1 << w) - 1;
        done = 0;
        if (rst) begin
            val = rv;
            tot = 0;
        end else if (en) begin
            if (mode == MODE_LOAD) begin
                val = int'(d_in) & mask;
                tot = 0;
            end else if (mode == MODE_SHR || mode == MODE_SHL) begin
                val = (mode == MODE_SHR) ? ((val >> 1) | (int'(ser_in_r) << (w - 1)))
                                         : (((val << 1) | int'(ser_in_l)) & mask);
                tot++;
                done = (tot % w == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic cyc(input logic r, input logic e, input usr_mode_t m,
                       input logic [3:0] di, input logic sr, input logic sl);
        exp_t x;
        int dn;
        @(negedge clk);
        rst = r; en = e; mode = m; d_in = di; ser_in_r = sr; ser_in_l = sl;
        model(4, 0, v4, t4, dn);
        x.d4 = v4; x.c4 = t4 % 4; x.w4 = dn; x.r4 = v4 & 1; x.l4 = (v4 >> 3) & 1;
        model(1, 1, v1, t1, dn);
        x.d1 = v1; x.c1 = 0; x.w1 = dn; x.r1 = v1; x.l1 = v1;
        q.push_back(x);
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("w4.d_out", 32'(d4), x.d4);
                chk("w4.shift_cnt", 32'(c4), x.c4);
                chk("w4.word_done", 32'(w4), x.w4);
                chk("w4.ser_out_r", 32'(r4), x.r4);
                chk("w4.ser_out_l", 32'(l4), x.l4);
                chk("w1.d_out", 32'(d1), x.d1);
                chk("w1.shift_cnt", 32'(c1), x.c1);
                chk("w1.word_done", 32'(w1), x.w1);
                chk("w1.ser_out_r", 32'(r1), x.r1);
                chk("w1.ser_out_l", 32'(l1), x.l1);
            end
        end
    end

    initial begin
        // reset wins over load
        cyc(1, 1, MODE_LOAD, 4'hF, 1, 1);
        // load 1011, shift out right
        cyc(0, 1, MODE_LOAD, 4'b1011, 0, 0);
        repeat (4) cyc(0, 1, MODE_SHR, 4'h0, 0, 0);
        cyc(0, 1, MODE_HOLD, 4'h0, 0, 0);
        // serial in from the left
        cyc(0, 1, MODE_LOAD, 4'h0, 0, 0);
        repeat (4) cyc(0, 1, MODE_SHL, 4'h0, 0, 1);
        // enable gating
        cyc(0, 1, MODE_LOAD, 4'hA, 0, 0);
        repeat (3) cyc(0, 0, MODE_LOAD, 4'h5, 1, 1);
        cyc(0, 0, MODE_SHR, 4'h5, 1, 1);
        // load mid-word
        repeat (2) cyc(0, 1, MODE_SHR, 4'h0, 1, 0);
        cyc(0, 1, MODE_LOAD, 4'h6, 0, 0);
        repeat (4) cyc(0, 1, MODE_SHL, 4'h0, 0, 1);
        // reset mid-word, then mixed directions
        repeat (3) cyc(0, 1, MODE_SHR, 4'h0, 1, 0);
        cyc(1, 1, MODE_SHR, 4'h0, 1, 0);
        cyc(0, 1, MODE_SHR, 4'h0, 1, 0);
        cyc(0, 1, MODE_SHL, 4'h0, 0, 0);
        cyc(0, 1, MODE_SHR, 4'h0, 0, 0);
        cyc(0, 1, MODE_SHL, 4'h0, 0, 1);
        // back-to-back shifts wrap continuously
        repeat (9) cyc(0, 1, MODE_SHL, 4'h0, 1, 0);
        // random traffic
        repeat (600) begin
            cyc($urandom_range(0, 40) == 0, $urandom_range(0, 7) != 0,
                usr_mode_t'($urandom_range(0, 3)), 4'($urandom),
                1'($urandom), 1'($urandom));
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
